irq_controller: RTL and testbench

- Four-source priority interrupt controller in front of the interrupt-vector decoder.
- Edge-detects and latches requests, applies a mask, arbitrates by fixed priority (source 0 highest), and raises a request to the CPU sequencer.
- On acknowledge, tracks the in-service level; the frozen 2-bit code feeds the vector decoder (codes 0..3 → 32'h00DB, 32'h010E, 32'h0141, 32'h0174).
- Releases the in-service level on return-from-interrupt.

---
 rtl/irq_pkg.sv | 31 +++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_controller.sv | 105 ++++++++++
 tb/tb_irq_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, FSM state type and vector addresses for the
// priority interrupt controller and its downstream vector decoder.
`default_nettype none

package irq_pkg;

    localparam int NSRC   = 4;
    localparam int CODE_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_t;

    localparam logic [31:0] VEC_ADDR_0 = 32'h0000_00DB;
    localparam logic [31:0] VEC_ADDR_1 = 32'h0000_010E;
    localparam logic [31:0] VEC_ADDR_2 = 32'h0000_0141;
    localparam logic [31:0] VEC_ADDR_3 = 32'h0000_0174;

    function automatic logic [31:0] vec_addr(input logic [CODE_W-1:0] code);
        case (code)
            2'd0:    return VEC_ADDR_0;
            2'd1:    return VEC_ADDR_1;
            2'd2:    return VEC_ADDR_2;
            default: return VEC_ADDR_3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: 4->2 lowest-index-wins priority encoder with valid flag.
`default_nettype none

module irq_prio_enc (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = 2'd0;
        valid = 1'b1;
        if (req[0])      idx = 2'd0;
        else if (req[1]) idx = 2'd1;
        else if (req[2]) idx = 2'd2;
        else if (req[3]) idx = 2'd3;
        else             valid = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// irq_controller: 4-source fixed-priority interrupt controller (source 0 highest).
// Build option IRQ_NESTING_EN enables preemption of a lower in-service level.
`default_nettype none

module irq_controller #(
    parameter int         NSRC     = 4,
    parameter logic [3:0] MASK_RST = 4'b0000
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    input  logic [NSRC-1:0] in_irq,
    input  logic            in_ie,
    input  logic            in_mask_we,
    input  logic [NSRC-1:0] in_mask_data,
    input  logic            in_ack,
    input  logic            in_iret,
    output logic            out_int_req,
    output logic [1:0]      out_code,
    output logic [NSRC-1:0] out_pending,
    output logic [NSRC-1:0] out_isr,
    output logic [NSRC-1:0] out_mask
);

    import irq_pkg::*;

    irq_state_t      state, state_n;
    logic [1:0]      code, code_n;
    logic [NSRC-1:0] irq_d, pending, isr, mask;

    logic [1:0]      cand_idx, cur_idx;
    logic            cand_valid, cur_valid;
    logic            eligible, ack_fire, iret_fire;
    logic [NSRC-1:0] rise, ack_set, iret_clr;

    irq_prio_enc u_cand_enc (
        .req   (pending & mask),
        .idx   (cand_idx),
        .valid (cand_valid)
    );

    irq_prio_enc u_level_enc (
        .req   (isr),
        .idx   (cur_idx),
        .valid (cur_valid)
    );

    assign rise      = in_irq & ~irq_d;
    assign ack_fire  = (state == REQ) && in_ack;
    assign iret_fire = in_iret && cur_valid;
    assign ack_set   = ack_fire  ? ({{(NSRC-1){1'b0}}, 1'b1} << code)    : '0;
    assign iret_clr  = iret_fire ? ({{(NSRC-1){1'b0}}, 1'b1} << cur_idx) : '0;

`ifdef IRQ_NESTING_EN
    assign eligible = in_ie && cand_valid && (!cur_valid || (cand_idx < cur_idx));
`else
    assign eligible = in_ie && cand_valid && !cur_valid;
`endif

    always_comb begin
        state_n = state;
        code_n  = code;
        case (state)
            IDLE: begin
                if (eligible) begin
                    state_n = REQ;
                    code_n  = cand_idx;
                end
            end
            REQ: begin
                // Committed request: only an acknowledge releases it.
                if (in_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state   <= IDLE;
            code    <= 2'd0;
            irq_d   <= '0;
            pending <= '0;
            isr     <= '0;
            mask    <= MASK_RST;
        end else begin
            state   <= state_n;
            code    <= code_n;
            irq_d   <= in_irq;
            // A fresh edge on the acknowledged source re-arms its latch.
            pending <= (pending & ~ack_set) | rise;
            // iret retires the level seen before this cycle's ack lands.
            isr     <= (isr & ~iret_clr) | ack_set;
            if (in_mask_we) mask <= in_mask_data;
        end
    end

    assign out_int_req = (state == REQ);
    assign out_code    = code;
    assign out_pending = pending;
    assign out_isr     = isr;
    assign out_mask    = mask;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller.
`default_nettype none

module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq;
    logic       ie, mask_we, ack, iret;
    logic [3:0] mask_data;
    logic       int_req;
    logic [1:0] code;
    logic [3:0] pending, isr, mask;

    int vectors = 0;
    int errors  = 0;

    irq_controller #(.NSRC(4), .MASK_RST(4'b0000)) dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .in_irq       (irq),
        .in_ie        (ie),
        .in_mask_we   (mask_we),
        .in_mask_data (mask_data),
        .in_ack       (ack),
        .in_iret      (iret),
        .out_int_req  (int_req),
        .out_code     (code),
        .out_pending  (pending),
        .out_isr      (isr),
        .out_mask     (mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_iret();
        iret = 1'b1; tick(); iret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = 4'h0; ie = 1'b0; mask_we = 1'b0; mask_data = 4'h0;
        ack = 1'b0; iret = 1'b0;
        #2;
        chk("rst_req", {31'd0, int_req}, 32'd0);
        chk("rst_code", {30'd0, code}, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'h0);
        chk("rst_isr", {28'd0, isr}, 32'h0);
        chk("rst_mask", {28'd0, mask}, 32'h0);
        tick();
        rst_n = 1'b1;

        // Single source, latency and acknowledge
        ie = 1'b1; mask_we = 1'b1; mask_data = 4'b1111; tick(); mask_we = 1'b0;
        chk("mask_load", {28'd0, mask}, 32'hF);
        irq = 4'b0100; tick();
        chk("t1_pend", {28'd0, pending}, 32'h4);
        chk("t1_noreq_yet", {31'd0, int_req}, 32'd0);
        irq = 4'b0000; tick();
        chk("t1_req", {31'd0, int_req}, 32'd1);
        chk("t1_code", {30'd0, code}, 32'd2);
        pulse_ack();
        chk("t1_isr", {28'd0, isr}, 32'h4);
        chk("t1_pend_clr", {28'd0, pending}, 32'h0);
        chk("t1_req_drop", {31'd0, int_req}, 32'd0);
        pulse_iret();
        chk("t1_iret", {28'd0, isr}, 32'h0);

        // Simultaneous sources: priority order
        irq = 4'b1010; tick(); irq = 4'b0000; tick();
        chk("t2_req", {31'd0, int_req}, 32'd1);
        chk("t2_code1", {30'd0, code}, 32'd1);
        pulse_ack();
        chk("t2_isr", {28'd0, isr}, 32'h2);
        chk("t2_pend", {28'd0, pending}, 32'h8);
        tick();
        chk("t2_blocked", {31'd0, int_req}, 32'd0);
        pulse_iret();
        chk("t2_iret", {28'd0, isr}, 32'h0);
        tick();
        chk("t2_req3", {31'd0, int_req}, 32'd1);
        chk("t2_code3", {30'd0, code}, 32'd3);
        pulse_ack(); pulse_iret();
        chk("t2_isr_clr", {28'd0, isr}, 32'h0);

        // Higher-priority arrival while a lower level is in service
        irq = 4'b0100; tick(); irq = 4'b0000; tick(); pulse_ack();
        chk("t3_isr2", {28'd0, isr}, 32'h4);
        irq = 4'b0001; tick(); irq = 4'b0000; tick();
`ifdef IRQ_NESTING_EN
        chk("t3_preempt_req", {31'd0, int_req}, 32'd1);
        chk("t3_preempt_code", {30'd0, code}, 32'd0);
        pulse_ack();
        chk("t3_nested_isr", {28'd0, isr}, 32'h5);
        pulse_iret();
        chk("t3_unnest_isr", {28'd0, isr}, 32'h4);
        pulse_iret();
        chk("t3_isr_clr", {28'd0, isr}, 32'h0);
`else
        chk("t3_no_preempt", {31'd0, int_req}, 32'd0);
        tick();
        chk("t3_no_preempt2", {31'd0, int_req}, 32'd0);
        pulse_iret();
        chk("t3_iret_isr", {28'd0, isr}, 32'h0);
        chk("t3_iret_noreq", {31'd0, int_req}, 32'd0);
        tick();
        chk("t3_late_req", {31'd0, int_req}, 32'd1);
        chk("t3_late_code", {30'd0, code}, 32'd0);
        pulse_ack(); pulse_iret();
        chk("t3_isr_clr", {28'd0, isr}, 32'h0);
`endif

        // Masked source stays pending until unmasked
        mask_we = 1'b1; mask_data = 4'b1110; tick(); mask_we = 1'b0;
        irq = 4'b0001; tick(); irq = 4'b0000; tick();
        chk("t4_pend_masked", {28'd0, pending}, 32'h1);
        chk("t4_noreq", {31'd0, int_req}, 32'd0);
        mask_we = 1'b1; mask_data = 4'b1111; tick(); mask_we = 1'b0;
        chk("t4_old_mask_arb", {31'd0, int_req}, 32'd0);
        tick();
        chk("t4_req", {31'd0, int_req}, 32'd1);
        chk("t4_code", {30'd0, code}, 32'd0);
        pulse_ack(); pulse_iret();

        // Committed request survives ie drop and higher-priority arrival
        irq = 4'b0100; tick(); irq = 4'b0000; tick();
        chk("t5_code2", {30'd0, code}, 32'd2);
        ie = 1'b0; irq = 4'b0001; tick(); irq = 4'b0000;
        chk("t5_hold_req", {31'd0, int_req}, 32'd1);
        chk("t5_hold_code", {30'd0, code}, 32'd2);
        tick();
        chk("t5_hold_code2", {30'd0, code}, 32'd2);
        irq = 4'b0100; ack = 1'b1; tick(); ack = 1'b0; irq = 4'b0000;
        chk("t5_pend_edge_wins", {28'd0, pending}, 32'h5);
        chk("t5_isr", {28'd0, isr}, 32'h4);
        chk("t5_req_drop", {31'd0, int_req}, 32'd0);

        // Asynchronous reset in the middle of a request
        ie = 1'b1; pulse_iret(); tick();
        chk("t6_req", {31'd0, int_req}, 32'd1);
        #2 rst_n = 1'b0; #1;
        chk("t6_rst_req", {31'd0, int_req}, 32'd0);
        chk("t6_rst_pend", {28'd0, pending}, 32'h0);
        chk("t6_rst_isr", {28'd0, isr}, 32'h0);
        chk("t6_rst_mask", {28'd0, mask}, 32'h0);
        tick();
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
